// File: rtl/get_put_pump.sv
// get_put_pump: pulls words from a Get interface into a small FIFO and pushes them to a Put interface.
// Define GET_PUT_PUMP_BYPASS_EN to let a word pass straight through when the FIFO is empty.
module get_put_pump #(
    parameter  int DATA_WIDTH = 1,
    parameter  int DEPTH      = 4,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] get,
    input  logic                  RDY_get,
    output logic                  EN_get,
    output logic [DATA_WIDTH-1:0] put,
    input  logic                  RDY_put,
    output logic                  EN_put,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wp;
    logic [PTR_W-1:0]      rp;
    logic                  full;
    logic                  empty;
    logic                  byp;
    logic                  wr;
    logic                  rd;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        EN_get = RDY_get & ~full & ~RST;
        EN_put = RDY_put & ~empty & ~RST;
        put    = RST ? '0 : mem[rp];
        byp    = 1'b0;
`ifdef GET_PUT_PUMP_BYPASS_EN
        // Empty with both sides ready: hand the word across without storing it
        if (empty && RDY_get && RDY_put && !RST) begin
            byp    = 1'b1;
            EN_put = 1'b1;
            put    = get;
        end
`endif
        wr = EN_get & ~byp;
        rd = EN_put & ~byp;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                mem[wp] <= get;
                wp      <= wp + PTR_W'(1);
            end
            if (rd) begin
                rp <= rp + PTR_W'(1);
            end
            case ({wr, rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_get_put_pump.sv
// Directed bench for get_put_pump: reset, fill/stall, full+dequeue, drain order,
// underflow, streaming with wrap-around, and the empty pass-through case.
module tb_get_put_pump;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef GET_PUT_PUMP_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [DW-1:0]    get = '0;
    logic             RDY_get = 1'b0;
    logic             RDY_put = 1'b0;
    logic             EN_get;
    logic             EN_put;
    logic [DW-1:0]    put;
    logic [CNT_W-1:0] count;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    int first_get = -1;

    logic [DW-1:0] src   [$];
    logic [DW-1:0] model [$];
    logic [DW-1:0] outq  [$];
    int            outcyc[$];

    always #5 CLK = ~CLK;

    get_put_pump #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .get    (get),
        .RDY_get(RDY_get),
        .EN_get (EN_get),
        .put    (put),
        .RDY_put(RDY_put),
        .EN_put (EN_put),
        .count  (count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given ready levels; expectations from a queue model
    task automatic cyc(input logic rg, input logic rpt);
        logic          eg;
        logic          ep;
        logic          byp;
        logic [DW-1:0] w;
        logic [DW-1:0] ew;
        w = (src.size() > 0) ? src[0] : '0;
        RDY_get = rg;
        RDY_put = rpt;
        get     = w;
        #1;
        byp = 1'b0;
`ifdef GET_PUT_PUMP_BYPASS_EN
        byp = rg && rpt && (model.size() == 0);
`endif
        eg = rg && (model.size() < DEPTH);
        ep = byp || (rpt && (model.size() > 0));
        ew = byp ? w : ((model.size() > 0) ? model[0] : '0);
        chk("en_get", 32'(EN_get), 32'(eg));
        chk("en_put", 32'(EN_put), 32'(ep));
        if (ep) begin
            chk("put", 32'(put), 32'(ew));
            outq.push_back(put);
            outcyc.push_back(ncyc);
        end
        if (eg && first_get < 0) first_get = ncyc;
        @(posedge CLK);
        #1;
        ncyc++;
        if (ep && !byp) void'(model.pop_front());
        if (eg) begin
            if (!byp) model.push_back(w);
            if (src.size() > 0) void'(src.pop_front());
        end
        chk("count", 32'(count), 32'(model.size()));
    endtask

    initial begin
        logic [DW-1:0] exp6 [6];
        exp6 = '{8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6};

        #1 RST = 1'b1;
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_en_get", 32'(EN_get), 0);
        chk("rst_en_put", 32'(EN_put), 0);
        chk("rst_put", 32'(put), 0);
        #9 RST = 1'b0;
        @(posedge CLK);
        #1;

        // Load three words, then hit reset mid-cycle
        src = '{8'h11, 8'h22, 8'h33};
        repeat (3) cyc(1'b1, 1'b0);
        chk("pre_rst_count", 32'(count), 3);
        #2;
        RDY_get = 1'b1;
        RDY_put = 1'b1;
        RST = 1'b1;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_en_get", 32'(EN_get), 0);
        chk("async_en_put", 32'(EN_put), 0);
        chk("async_put", 32'(put), 0);
        RDY_get = 1'b0;
        RDY_put = 1'b0;
        #1 RST = 1'b0;
        model.delete();
        src.delete();
        @(posedge CLK);
        #1;
        chk("post_rst_count", 32'(count), 0);

        // Fill and stall
        outq.delete();
        src = '{8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6};
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
        chk("fill_count", 32'(count), 4);
        chk("fill_left", 32'(src.size()), 2);

        // Full with simultaneous dequeue, then both transfer
        cyc(1'b1, 1'b1);
        chk("full_deq_count", 32'(count), 3);
        cyc(1'b1, 1'b1);
        chk("both_count", 32'(count), 3);

        // Drain the rest
        for (int i = 0; i < 6; i++) cyc(src.size() > 0, 1'b1);
        chk("drain_n", 32'(outq.size()), 6);
        for (int i = 0; i < 6; i++)
            chk("drain_order",
                (i < outq.size()) ? 32'(outq[i]) : 32'hdead,
                32'(exp6[i]));

        // Underflow
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk("under_count", 32'(count), 0);

        // Streaming with pointer wrap
        outq.delete();
        outcyc.delete();
        first_get = -1;
        for (int i = 0; i < 20; i++) src.push_back(DW'(i));
        for (int i = 0; i < 22; i++) cyc(src.size() > 0, 1'b1);
        chk("stream_n", 32'(outq.size()), 20);
        for (int i = 0; i < 20; i++)
            chk("stream_order",
                (i < outq.size()) ? 32'(outq[i]) : 32'hdead, 32'(i));
        if (outq.size() == 20) begin
            chk("stream_lat", 32'(outcyc[0] - first_get), 32'(LAT));
            chk("stream_gap", 32'(outcyc[19] - outcyc[0]), 19);
        end else begin
            chk("stream_len", 32'(outq.size()), 20);
        end

        // Empty, both ready, single word 0xA
        outq.delete();
        src = '{8'h0A};
        cyc(1'b1, 1'b1);
`ifdef GET_PUT_PUMP_BYPASS_EN
        chk("byp_count", 32'(count), 0);
        chk("byp_n", 32'(outq.size()), 1);
`else
        chk("nobyp_count", 32'(count), 1);
        chk("nobyp_n", 32'(outq.size()), 0);
        cyc(1'b0, 1'b1);
        chk("nobyp_out_n", 32'(outq.size()), 1);
`endif
        chk("single_word",
            (outq.size() > 0) ? 32'(outq[0]) : 32'hdead, 32'h0A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
